vga_fb_arbiter: RTL and testbench

Shares one single-port framebuffer RAM between display scan-out and CPU pixel writes for the vga display path. Prefetches pixels in raster order into a small FIFO that the display timing logic drains one pixel per active-video pixel clock. CPU writes use a valid/ready handshake and are serviced in cycles the display does not need. Sits between the vga timing/colour logic and the framebuffer memory.

---
 rtl/vga_pkg.sv | 15 +
 rtl/vga_pix_fifo.sv | 48 ++++
 rtl/vga_fb_arbiter.sv | 109 ++++++++++
 tb/tb_vga_fb_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer path (640x480, RGB332).
package vga_pkg;
  localparam int HPIX     = 640;
  localparam int VPIX     = 480;
  localparam int FB_WORDS = HPIX * VPIX;
  localparam int PIX_W    = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    FILL,
    STREAM,
    DONE
  } fb_state_t;
endpackage

// File: rtl/vga_pix_fifo.sv
// Pixel prefetch FIFO: push/pop with 1-cycle update, head visible the cycle after push.
// Pop on empty is ignored; flush wins over push and pop. Head reads 0 when empty.
module vga_pix_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = (count == '0) ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer between raster prefetch and CPU writes; reads land in the FIFO 1 cycle after issue.
// CPU writes stall (cpu_wready=0) while the display needs the port; the display never backpressures.
module vga_fb_arbiter #(
  parameter int AW       = 19,
  parameter int DW       = 8,
  parameter int FB_WORDS = vga_pkg::FB_WORDS,
  parameter int DEPTH    = 8,
  parameter int LOW_WM   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vsync_start,
  input  logic          pix_rd,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic          underflow,
  input  logic          cpu_wvalid,
  input  logic [AW-1:0] cpu_waddr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_wready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  import vga_pkg::*;

  localparam int          CW     = $clog2(DEPTH) + 1;
  localparam logic [AW:0] FB_LIM = (AW+1)'(FB_WORDS);

  fb_state_t     state;
  logic [AW:0]   rd_ptr;
  logic          inflight;
  logic [CW-1:0] count;
  logic [CW-1:0] occ;
  logic [CW:0]   occ_next;
  logic          rd_legal;
  logic          do_rd;
  logic          do_wr;
  logic          wr_in_range;
  logic          rd_last;

  vga_pix_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .pop   (pix_rd),
    .flush (vsync_start),
    .wdata (mem_rdata),
    .head  (pix_data),
    .count (count)
  );

  assign pix_valid = (count != '0);

  // occ counts the read in flight so a full FIFO can never be over-requested
  assign occ = count + CW'(inflight);

  always_comb begin
    rd_legal    = (occ < CW'(DEPTH)) && (rd_ptr < FB_LIM);
    wr_in_range = ({1'b0, cpu_waddr} < FB_LIM);
    do_rd       = 1'b0;
    if (!reset && !vsync_start) begin
      case (state)
        FILL:    do_rd = rd_legal;
        STREAM:  do_rd = rd_legal && ((occ < CW'(LOW_WM)) || !cpu_wvalid);
        default: do_rd = 1'b0;
      endcase
    end
    do_wr      = !reset && cpu_wvalid && (state != FILL) && !do_rd;
    cpu_wready = do_wr;
    mem_en     = do_rd || (do_wr && wr_in_range);
    mem_we     = do_wr && wr_in_range;
    mem_addr   = do_rd ? rd_ptr[AW-1:0] : (mem_we ? cpu_waddr : '0);
    mem_wdata  = mem_we ? cpu_wdata : '0;
    rd_last    = do_rd && (rd_ptr == FB_LIM - (AW+1)'(1));
    occ_next   = {1'b0, count} + (CW+1)'(inflight)
               - (CW+1)'(pix_rd && pix_valid) + (CW+1)'(do_rd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      rd_ptr    <= '0;
      inflight  <= 1'b0;
      underflow <= 1'b0;
    end else if (vsync_start) begin
      state     <= FILL;
      rd_ptr    <= '0;
      inflight  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      inflight <= do_rd;
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (pix_rd && !pix_valid) underflow <= 1'b1;
      case (state)
        FILL: begin
          if (rd_last) state <= DONE;
          else if (occ_next >= (CW+1)'(DEPTH)) state <= STREAM;
        end
        STREAM: begin
          if (rd_last) state <= DONE;
        end
        default: state <= DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboarded bench: raster-order pixel queue, CPU write queue and an occupancy model built from the arbitration rules.
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  localparam int AW = 19, DW = 8, FBW = 16, DEPTH = 8, LOW_WM = 4, WAIT_MAX = 40;

  logic          clk = 1'b0;
  logic          reset, vsync_start, pix_rd, cpu_wvalid;
  logic [AW-1:0] cpu_waddr, mem_addr;
  logic [DW-1:0] cpu_wdata, pix_data, mem_wdata, mem_rdata;
  logic          pix_valid, underflow, cpu_wready, mem_en, mem_we;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  int     nvec = 0;
  int     nerr = 0;
  wr_t    wq[$];
  pixel_t pixq[$];
  int     mcnt, mptr, wait_cnt;
  bit     mpend, munder, mfilled;
  bit     pend_rd, acc_flag;
  logic [AW-1:0] pend_addr;

  vga_fb_arbiter #(.AW(AW), .DW(DW), .FB_WORDS(FBW), .DEPTH(DEPTH), .LOW_WM(LOW_WM)) dut (
    .clk(clk), .reset(reset), .vsync_start(vsync_start), .pix_rd(pix_rd),
    .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
    .cpu_wvalid(cpu_wvalid), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_wready(cpu_wready), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic pixel_t pat(int a);
    return pixel_t'((a * 37 + 11) & 255);
  endfunction

  task automatic chk(string name, longint act, longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic new_frame();
    pixq.delete();
    for (int i = 0; i < FBW; i++) pixq.push_back(pat(i));
    mcnt = 0; mpend = 0; mptr = 0; munder = 0; mfilled = 0;
  endtask

  // RAM: read data appears for exactly the cycle after the read, junk otherwise
  initial begin
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_rdata = pend_rd ? pat(int'(pend_addr)) : DW'($urandom);
    end
  end

  always @(negedge clk) begin : mon
    int  occ;
    bit  legal, exp_rd, exp_wr, is_rd;
    wr_t w;
    if (reset) begin
      chk("rst_mem_en", mem_en, 0);
      chk("rst_wready", cpu_wready, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_underflow", underflow, 0);
      chk("rst_pix_data", pix_data, 0);
      new_frame();
      pend_rd = 0; acc_flag = 0;
    end else begin
      occ    = mcnt + int'(mpend);
      legal  = (occ < DEPTH) && (mptr < FBW);
      exp_rd = !vsync_start && legal && (!mfilled || occ < LOW_WM || !cpu_wvalid);
      exp_wr = cpu_wvalid && !exp_rd && mfilled;
      is_rd  = mem_en && !mem_we;
      chk("rd_issue", is_rd, exp_rd);
      if (is_rd) chk("rd_addr", mem_addr, mptr);
      chk("cpu_wready", cpu_wready, exp_wr);
      if (cpu_wready) begin
        chk("wq_nonempty", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          w = wq.pop_front();
          if (w.addr < FBW) begin
            chk("wr_mem_en", mem_en, 1);
            chk("wr_mem_we", mem_we, 1);
            chk("wr_addr", mem_addr, w.addr);
            chk("wr_data", mem_wdata, w.data);
          end else begin
            chk("wr_drop_mem_en", mem_en, 0);
          end
        end
      end
      chk("pix_valid", pix_valid, mcnt > 0);
      chk("pix_data", pix_data, (mcnt > 0) ? pixq[0] : 0);
      chk("underflow", underflow, munder);
      if (vsync_start) begin
        new_frame();
      end else begin
        if (pix_rd) begin
          if (mcnt > 0) begin
            void'(pixq.pop_front());
            mcnt--;
          end else begin
            munder = 1;
          end
        end
        if (mpend) mcnt++;
        mpend = is_rd;
        if (is_rd) mptr++;
        if ((mcnt + int'(mpend)) >= DEPTH || (is_rd && mptr == FBW)) mfilled = 1;
      end
      pend_rd   = is_rd;
      pend_addr = mem_addr;
      acc_flag  = cpu_wready;
    end
  end

  task automatic step();
    @(posedge clk); #1;
    if (cpu_wvalid && acc_flag) begin
      chk("wr_latency_ok", wait_cnt <= WAIT_MAX, 1);
      cpu_wvalid = 0;
      wait_cnt   = 0;
    end else if (cpu_wvalid) begin
      wait_cnt++;
    end
  endtask

  task automatic new_req(logic [AW-1:0] a, logic [DW-1:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    cpu_wvalid = 1; cpu_waddr = a; cpu_wdata = d;
    wq.push_back(w);
    wait_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, nvec=%0d", nvec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] done_addrs [8];
    done_addrs = '{20, 3, 15, 16, 0, 20, 7, 9};
    reset = 1; vsync_start = 0; pix_rd = 0; cpu_wvalid = 0;
    cpu_waddr = '0; cpu_wdata = '0; wait_cnt = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // Fill from reset with no traffic, then CPU writes against a full FIFO
    repeat (12) step();
    for (int i = 0; i < 5; i++) begin
      if (!cpu_wvalid) new_req(AW'(5), DW'(8'hAB + i));
      step();
    end

    // Underflow right after vsync, then vsync while a read is in flight
    vsync_start = 1;
    step(); vsync_start = 0; pix_rd = 1;
    step(); pix_rd = 0;
    repeat (4) step();
    vsync_start = 1;
    step(); vsync_start = 0;
    repeat (12) step();

    // Random traffic across several frames
    for (int i = 0; i < 600; i++) begin
      step();
      vsync_start = ($urandom_range(0, 79) == 0);
      pix_rd = !vsync_start && ($urandom_range(0, 3) == 0);
      if (vsync_start) wait_cnt = 0;
      if (!cpu_wvalid && $urandom_range(0, 2) == 0)
        new_req(AW'($urandom_range(0, 23)), DW'($urandom));
    end

    // Drain a whole frame into DONE, then back-to-back CPU writes
    step(); vsync_start = 1; pix_rd = 0; wait_cnt = 0;
    step(); vsync_start = 0;
    for (int i = 0; i < 90; i++) begin
      pix_rd = ($urandom_range(0, 1) == 1);
      step();
    end
    pix_rd = 0;
    while (cpu_wvalid) step();
    for (int i = 0; i < 8; i++) begin
      new_req(done_addrs[i], DW'(8'h40 + i));
      step();
      chk("done_accept", cpu_wvalid, 0);
    end
    for (int i = 0; i < 5 && cpu_wvalid; i++) step();
    cpu_wvalid = 0;
    step();
    chk("wq_drained", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
